rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Round-robin arbiter that shares the register file's single write port between several writeback sources (ALU, load unit, multiply unit). Requests use a valid/ready handshake, and the arbiter grants at most one per cycle. Each granted write is registered and presented to the register file's write_reg, write_data and reg_write inputs one cycle later. Writes to register 30 are discarded, because the register file overwrites that register from R_in every cycle.

## Interface
Parameters:
- N_REQ, 3, number of writeback requesters (2..8)
- STAT_W, 16, width of the statistics counters

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- wb_hold  in  1  when high, no grants are issued
- req_valid  in  N_REQ  requester i has a write pending
- req_addr  in  5*N_REQ  destination register; slice i is [5i+4:5i]
- req_data  in  32*N_REQ  write data (signed 32-bit); slice i is [32i+31:32i]
- req_ready  out  N_REQ  one-hot grant; the transfer completes when valid&ready
- reg_write  out  1  write enable to the register file
- write_reg  out  5  write address to the register file
- write_data  out  32  write data to the register file
- pending_mask  out  32  bit k high while a write to register k sits in the output register
- drop_cnt  out  STAT_W  number of discarded writes to register 30
- conflict_cnt  out  STAT_W  number of cycles with more than one valid request and a grant issued

## Operation
- Round-robin pointer ptr, range 0..N_REQ-1, reset value 0.
- Search order is ptr, ptr+1, …, wrapping modulo N_REQ. The first requester with req_valid high is granted.
- req_ready is combinational:
  - it is zero when wb_hold=1 or rst=1;
  - otherwise at most one bit is set.
  - req_ready never depends on req_data.
- Pointer update:
  - after a grant to requester g, ptr becomes (g+1) mod N_REQ;
  - with no grant, ptr is unchanged.
- Output register, on a grant:
  - address ≠ 30: reg_write=1, and write_reg/write_data take the granted slices;
  - address = 30: the grant still completes (requester sees ready), but reg_write=0 and drop_cnt increments.
- With no grant, reg_write=0 on the next cycle. write_reg and write_data hold their last values.
- Address 0 is an ordinary writable register and is not filtered.
- Two requesters targeting the same address are granted in different cycles. The later grant's data is final in the register file.
- pending_mask = reg_write ? (1 << write_reg) : 0. It is used by issue logic for read-after-write stalls.
- Counters saturate at all-ones.
  - conflict_cnt counts cycles with a grant and popcount(req_valid) > 1. Cycles under wb_hold are not counted.

## Timing
- Reset values: reg_write=0, write_reg=0, write_data=0, ptr=0, pending_mask=0, drop_cnt=0, conflict_cnt=0, req_ready=0.
- Latency: a grant at edge E0 gives reg_write high for the cycle E0→E1. The register file commits at edge E1, so the data is readable from the register file after E1.
- Throughput is one write per cycle. A requester holding valid high is granted within N_REQ cycles while wb_hold=0.
- Requesters must hold valid, addr and data stable until ready. Dropping valid before grant is permitted.
- If wb_hold rises while a write sits in the output register, that write still commits at the next edge. No new grant is issued.
- If rst is asserted mid-operation, the write in the output register is discarded. reg_write is 0 on the cycle after the reset edge.

## Configuration
- RF_WB_ARB_STATS_EN defined: drop_cnt and conflict_cnt are implemented as described.
- RF_WB_ARB_STATS_EN undefined: the ports remain but are tied to 0 and no counter flops exist. Discarding of address-30 writes is unchanged.

## Structure
- Package rf_wb_pkg holds:
  - RF_ADDR_W=5, RF_DATA_W=32, RF_NREGS=32;
  - RF_RIN_ADDR=30;
  - the typedef for a writeback request {addr, data}.
- Sub-module rr_arbiter:
  - parameter N;
  - inputs req[N-1:0] and an enable;
  - outputs a one-hot grant, plus a grant index and a grant-valid flag.
  - It owns ptr.
- The top level owns the output register, the address-30 filter, pending_mask and the counters.

## Test plan
- After reset, all requesters valid at addresses 1, 2, 3 with data 11, 22, 33, wb_hold=0:
  - grants are issued to 0, 1, 2 on consecutive cycles;
  - register file holds R1=11, R2=22, R3=33 after four edges;
  - conflict_cnt=2.
- Requester 1 valid continuously at address 5 with data -7, others idle: granted every cycle; ptr stays at 2 after each grant; pending_mask=0x20 while reg_write=1.
- Requester 0 writes address 30 with data 99: ready=1 and reg_write stays 0; drop_cnt=1; R30 continues to track R_in.
- wb_hold=1 for 3 cycles with all requesters valid: req_ready=0 and reg_write=0 from the second cycle; on release, the grant goes to the requester at the pre-hold ptr.
- Requesters 0 and 2 both write address 4 (data 1 and data 2) with ptr=0: final R4=2.
- rst asserted the cycle after a grant to address 7: reg_write=0, R7 unchanged, and all counters are 0 after the reset edge.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_pkg
// Shared constants and types for the register-file writeback arbiter.
//   RF_ADDR_W / RF_DATA_W / RF_NREGS : register file geometry
//   RF_RIN_ADDR                      : register that the register file reloads
//                                      from R_in every cycle, so writeback
//                                      writes to it are dropped
//   wb_req_t                         : one writeback request {addr, data}
// -----------------------------------------------------------------------------
package rf_wb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_NREGS  = 32;

  localparam logic [RF_ADDR_W-1:0] RF_RIN_ADDR = 5'd30;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered priority pointer. The grant is purely
// combinational from req, en and the pointer; the pointer moves to one past
// the granted requester after every grant and holds otherwise.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   en        : when low no grant is issued
//   req       : request vector
//   gnt       : one-hot grant
//   gnt_idx   : index of the granted requester (valid when gnt_vld)
//   gnt_vld   : a grant is issued this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_pos;

  // Walk the requesters starting at the pointer, wrapping at N; the first
  // active request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(N)) begin
        w_pos = w_pos - (IDX_W+1)'(N);
      end
      if (en && !gnt_vld && req[w_pos[IDX_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = w_pos[IDX_W-1:0];
      end
    end
    if (gnt_vld) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (gnt_vld) begin
      r_ptr <= (gnt_idx == IDX_W'(N-1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file's single write port between N_REQ writeback
// sources. One request is granted per cycle (round robin), registered, and
// presented to the register file on the following cycle. Writes to the R_in
// register (30) complete the handshake but are never written.
// Optional feature macro: RF_WB_ARB_STATS_EN -- when defined, drop_cnt and
// conflict_cnt are saturating counters; otherwise both read as 0.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   wb_hold       : suppresses all grants while high
//   req_valid     : per-requester write pending
//   req_addr      : packed 5-bit destination registers, slice i = [5i+4:5i]
//   req_data      : packed 32-bit data, slice i = [32i+31:32i]
//   req_ready     : one-hot grant (combinational)
//   reg_write     : register file write enable
//   write_reg     : register file write address
//   write_data    : register file write data
//   pending_mask  : one-hot of the register being written this cycle
//   drop_cnt      : writes discarded because they targeted register 30
//   conflict_cnt  : granted cycles with more than one valid request
// -----------------------------------------------------------------------------
module rf_write_arbiter
  import rf_wb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int STAT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_hold,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [5*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 reg_write,
  output logic [4:0]           write_reg,
  output logic [31:0]          write_data,
  output logic [31:0]          pending_mask,
  output logic [STAT_W-1:0]    drop_cnt,
  output logic [STAT_W-1:0]    conflict_cnt
);

  localparam int IDX_W = $clog2(N_REQ);

  wb_req_t          w_req [N_REQ];
  wb_req_t          w_gnt_req;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_gnt_vld;
  logic             w_en;
  logic             w_is_rin;

  logic                 r_reg_write;
  logic [RF_ADDR_W-1:0] r_write_reg;
  logic [RF_DATA_W-1:0] r_write_data;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_req[gi] = {req_addr[gi*RF_ADDR_W +: RF_ADDR_W],
                          req_data[gi*RF_DATA_W +: RF_DATA_W]};
    end
  endgenerate

  // Gating on rst keeps req_ready low during reset so no requester believes
  // a transfer completed that the output register is about to clear.
  assign w_en = !wb_hold && !rst;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .en      (w_en),
    .req     (req_valid),
    .gnt     (req_ready),
    .gnt_idx (w_gnt_idx),
    .gnt_vld (w_gnt_vld)
  );

  assign w_gnt_req = w_req[w_gnt_idx];
  assign w_is_rin  = (w_gnt_req.addr == RF_RIN_ADDR);

  // Dropped R30 writes leave write_reg/write_data untouched; only reg_write
  // matters for them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (w_gnt_vld && !w_is_rin) begin
      r_reg_write  <= 1'b1;
      r_write_reg  <= w_gnt_req.addr;
      r_write_data <= w_gnt_req.data;
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  // A reset arriving while a write sits in the output register must stop it
  // from committing at the reset edge, hence the combinational gate.
  assign reg_write    = r_reg_write & ~rst;
  assign write_reg    = r_write_reg;
  assign write_data   = r_write_data;
  assign pending_mask = reg_write ? (32'd1 << r_write_reg) : 32'd0;

`ifdef RF_WB_ARB_STATS_EN
  logic              w_multi;
  logic [STAT_W-1:0] r_drop_cnt;
  logic [STAT_W-1:0] r_conflict_cnt;

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign w_multi = |(req_valid & (req_valid - N_REQ'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_gnt_vld && w_is_rin && !(&r_drop_cnt)) begin
        r_drop_cnt <= r_drop_cnt + STAT_W'(1);
      end
      if (w_gnt_vld && w_multi && !(&r_conflict_cnt)) begin
        r_conflict_cnt <= r_conflict_cnt + STAT_W'(1);
      end
    end
  end

  assign drop_cnt     = r_drop_cnt;
  assign conflict_cnt = r_conflict_cnt;
`else
  assign drop_cnt     = '0;
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
// Drives rf_write_arbiter (N_REQ=3) against a small register file model and a
// reference round-robin model. Each cycle the expected grant is computed from
// the inputs, the expected output-register content is pushed to a queue, and
// it is popped and compared one edge later.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

  localparam int N  = 3;
  localparam int SW = 16;
`ifdef RF_WB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_hold;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_addr;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            reg_write;
  logic [4:0]      write_reg;
  logic [31:0]     write_data;
  logic [31:0]     pending_mask;
  logic [SW-1:0]   drop_cnt;
  logic [SW-1:0]   conflict_cnt;

  logic [4:0]  a [N];
  logic [31:0] d [N];

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[5*i +: 5]   = a[i];
      req_data[32*i +: 32] = d[i];
    end
  end

  rf_write_arbiter #(.N_REQ(N), .STAT_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_hold      (wb_hold),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .pending_mask (pending_mask),
    .drop_cnt     (drop_cnt),
    .conflict_cnt (conflict_cnt)
  );

  // Register file fed by the DUT; R30 reloads from R_in every cycle.
  logic [31:0] rf [32];
  logic [31:0] r_in = 32'h1000;
  always @(posedge clk) begin
    if (reg_write) rf[write_reg] <= write_data;
    rf[30] <= r_in;
    r_in   <= r_in + 32'd1;
  end

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   m_ptr;
  int   exp_drop;
  int   exp_conf;
  bit   auto_clear;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: predict the grant, check req_ready mid-cycle, then
  // check the output register after the edge.
  task automatic cycle();
    logic [N-1:0] er;
    int           g;
    int           idx;
    bit           rs;
    exp_t         e;
    exp_t         o;
    @(negedge clk);
    rs = rst;
    er = '0;
    g  = -1;
    if (!wb_hold && !rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (req_valid[idx] && g < 0) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    if (rs) check("reg_write_in_rst", 32'(reg_write), 32'd0);
    e.wr = 1'b0; e.addr = '0; e.data = '0;
    if (g >= 0) begin
      $display("grant req=%0d addr=%0d data=%0d", g, a[g], $signed(d[g]));
      m_ptr  = (g + 1) % N;
      e.wr   = (a[g] != 5'd30);
      e.addr = a[g];
      e.data = d[g];
      if (a[g] == 5'd30) exp_drop++;
      if ($countones(req_valid) > 1) exp_conf++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (rs) begin
      sb.delete();
      m_ptr = 0; exp_drop = 0; exp_conf = 0;
      check("rst_reg_write", 32'(reg_write), 32'd0);
      check("rst_pending", pending_mask, 32'd0);
    end else if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      o = sb.pop_front();
      check("reg_write", 32'(reg_write), 32'(o.wr));
      check("pending_mask", pending_mask, o.wr ? (32'd1 << o.addr) : 32'd0);
      if (o.wr) begin
        check("write_reg", 32'(write_reg), 32'(o.addr));
        check("write_data", write_data, o.data);
      end
    end
    check("drop_cnt", 32'(drop_cnt), STATS ? 32'(exp_drop) : 32'd0);
    check("conflict_cnt", 32'(conflict_cnt), STATS ? 32'(exp_conf) : 32'd0);
    if (g >= 0 && auto_clear) req_valid[g] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
    rst = 1'b1; wb_hold = 1'b0; req_valid = '1;
    m_ptr = 0; exp_drop = 0; exp_conf = 0; auto_clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_reg_write0", 32'(reg_write), 32'd0);
    check("rst_write_reg", 32'(write_reg), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_pending0", pending_mask, 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_conf", 32'(conflict_cnt), 32'd0);
    req_valid = '0;
    rst = 1'b0;

    // All three requesters at once: grants 0,1,2 back to back.
    a[0] = 5'd1; d[0] = 32'd11;
    a[1] = 5'd2; d[1] = 32'd22;
    a[2] = 5'd3; d[2] = 32'd33;
    req_valid = 3'b111;
    repeat (4) cycle();
    check("R1", rf[1], 32'd11);
    check("R2", rf[2], 32'd22);
    check("R3", rf[3], 32'd33);
    check("conf_after_burst", 32'(conflict_cnt), STATS ? 32'd2 : 32'd0);

    // Requester 1 streaming to R5.
    auto_clear = 1'b0;
    a[1] = 5'd5; d[1] = -32'sd7;
    req_valid = 3'b010;
    repeat (4) cycle();
    req_valid = '0;
    cycle();
    check("R5", rf[5], 32'hFFFF_FFF9);
    auto_clear = 1'b1;

    // Write to the R_in register is swallowed.
    a[0] = 5'd30; d[0] = 32'd99;
    req_valid = 3'b001;
    repeat (2) cycle();
    check("drop_after_r30", 32'(drop_cnt), STATS ? 32'd1 : 32'd0);

    // Hold with everyone valid, then release: order 1,2,0.
    a[0] = 5'd8;  d[0] = 32'd100;
    a[1] = 5'd9;  d[1] = 32'd101;
    a[2] = 5'd10; d[2] = 32'd102;
    req_valid = 3'b111;
    wb_hold = 1'b1;
    repeat (3) cycle();
    wb_hold = 1'b0;
    repeat (4) cycle();
    check("R8", rf[8], 32'd100);
    check("R9", rf[9], 32'd101);
    check("R10", rf[10], 32'd102);

    // Bring the pointer back to 0, then two writers to R4.
    a[2] = 5'd11; d[2] = 32'd5;
    req_valid = 3'b100;
    repeat (2) cycle();
    a[0] = 5'd4; d[0] = 32'd1;
    a[2] = 5'd4; d[2] = 32'd2;
    req_valid = 3'b101;
    repeat (3) cycle();
    check("R4_last_wins", rf[4], 32'd2);

    // Reset right after a grant to R7 throws that write away.
    a[1] = 5'd7; d[1] = 32'd77;
    req_valid = 3'b010;
    cycle();
    rst = 1'b1;
    req_valid = 3'b011;
    cycle();
    req_valid = '0;
    rst = 1'b0;
    repeat (2) cycle();
    check("R7_untouched", rf[7], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
